// File: rtl/xosera_pkg.sv
// Shared types for the Xosera video blocks: the color memory word and the
// color-memory readback controller state encoding.
package xosera_pkg;

    localparam int WORD_W = 16;

    // one color memory entry
    typedef logic [WORD_W-1:0] word_t;

    // readback controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        ISSUE = 3'd2,
        CAPT  = 3'd3,
        HOLD  = 3'd4
    } color_rb_state_t;

endpackage

// File: rtl/color_readback.sv
// Host readback of color memory. The block borrows the color memory read port
// for a single cycle, preferably while the video path is idle. If no idle slot
// turns up within MAX_WAIT cycles, it takes the port anyway and records that in
// a sticky flag. The captured word is held until the host acknowledges it.
module color_readback
    import xosera_pkg::*;
#(
    parameter int AWIDTH   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic              auto_inc_i,
    input  logic              rd_ack_i,
    input  logic              vid_idle_i,
    input  word_t             cm_rd_data_i,
    output logic              cm_rd_sel_o,
    output logic [AWIDTH-1:0] cm_rd_addr_o,
    output word_t             rd_data_o,
    output logic              rd_valid_o,
    output logic              busy_o,
    output logic [AWIDTH-1:0] cur_addr_o,
    output logic              drop_o,
    output logic              forced_o
);

    // A MAX_WAIT of 0 would give a zero-width counter, so keep at least one bit.
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    color_rb_state_t   state_reg;
    color_rb_state_t   state_next;
    logic [AWIDTH-1:0] addr_reg;
    logic              inc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    word_t             data_reg;
    logic              drop_reg;
    logic              forced_reg;

    logic accept;      // a new request is latched this cycle
    logic wait_done;   // counter has reached its limit
    logic force_evt;   // leaving WAIT only because of the timeout
    logic cnt_tick;    // still waiting, advance the counter

    assign wait_done = (cnt_reg == CNT_MAX);
    assign force_evt = (state_reg == WAIT) && !vid_idle_i && wait_done;
    assign cnt_tick  = (state_reg == WAIT) && !vid_idle_i && !wait_done;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state decode and request acceptance
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_i) begin
                    state_next = WAIT;
                    accept     = 1'b1;
                end
            end
            WAIT: begin
                if (vid_idle_i || wait_done) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = CAPT;
            CAPT:  state_next = HOLD;
            HOLD: begin
                if (rd_ack_i) begin
                    if (req_i) begin
                        state_next = WAIT;
                        accept     = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // request latch, wait counter, capture and address post-increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg <= '0;
            inc_reg  <= 1'b0;
            cnt_reg  <= '0;
            data_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg <= req_addr_i;
                inc_reg  <= auto_inc_i;
                cnt_reg  <= '0;
            end else begin
                if (cnt_tick) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                if (state_reg == CAPT) begin
                    // memory data arrives one cycle after the ISSUE address
                    data_reg <= cm_rd_data_i;
                    if (inc_reg) begin
                        addr_reg <= addr_reg + AWIDTH'(1);
                    end
                end
            end
        end
    end

    // drop pulse for rejected requests and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_reg   <= 1'b0;
            forced_reg <= 1'b0;
        end else begin
            drop_reg   <= req_i && !accept;
            forced_reg <= forced_reg || force_evt;
        end
    end

    assign cm_rd_sel_o  = (state_reg == ISSUE);
    assign cm_rd_addr_o = addr_reg;
    assign rd_data_o    = data_reg;
    assign rd_valid_o   = (state_reg == HOLD);
    assign busy_o       = (state_reg != IDLE);
    assign cur_addr_o   = addr_reg;
    assign drop_o       = drop_reg;
    assign forced_o     = forced_reg;

endmodule
